// File: rtl/serial_bus_pkg.sv
// Shared definitions for the bit-serial bus: arbiter state encoding,
// owner codes and the default watchdog length.
package serial_bus_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I1   = 2'b01;
  localparam logic [1:0] OWNER_I2   = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/bus_arbiter.sv
// Two-initiator round-robin arbiter for the bit-serial bus, with a watchdog
// that reclaims the bus from an owner that stops presenting valid bits.
module bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init1_req,
  input  logic       init2_req,
  input  logic       init1_data,
  input  logic       init2_data,
  input  logic       init1_valid,
  input  logic       init2_valid,
  input  logic       init1_mode,
  input  logic       init2_mode,
  input  logic       init1_rw,
  input  logic       init2_rw,
  output logic       init1_grant,
  output logic       init2_grant,
  output logic       bus_data_out,
  output logic       bus_data_out_valid,
  output logic       bus_mode_out,
  output logic       bus_rw_out,
  output logic [1:0] owner,
  output logic       timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state;
  logic [1:0]       owner_q;
  logic [1:0]       last_owner;
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_q;

  logic       own_req;
  logic       own_valid;
  logic [1:0] winner;
  logic       wd_fire;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    own_req   = 1'b0;
    own_valid = 1'b0;
    case (owner_q)
      OWNER_I1: begin
        own_req   = init1_req;
        own_valid = init1_valid;
      end
      OWNER_I2: begin
        own_req   = init2_req;
        own_valid = init2_valid;
      end
      default: ;
    endcase
  end

  // On a tie the initiator that did not own the bus last goes first.
  always_comb begin
    winner = OWNER_NONE;
    if (init1_req && (!init2_req || last_owner == OWNER_I2))
      winner = OWNER_I1;
    else if (init2_req)
      winner = OWNER_I2;
  end

  assign wd_fire = (state == ARB_BUSY) && own_req && !own_valid && (idle_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner_q    <= OWNER_NONE;
      last_owner <= OWNER_I2;
      idle_cnt   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (winner != OWNER_NONE) begin
            owner_q    <= winner;
            last_owner <= winner;
            idle_cnt   <= '0;
            state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!own_req) begin
            owner_q <= OWNER_NONE;
            state   <= ARB_IDLE;
          end else if (wd_fire) begin
            owner_q   <= OWNER_NONE;
            timeout_q <= 1'b1;
            state     <= ARB_IDLE;
          end else if (own_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Grants decode the owner register, so async reset drops them at once.
  assign init1_grant = (owner_q == OWNER_I1);
  assign init2_grant = (owner_q == OWNER_I2);
  assign owner       = owner_q;
  assign timeout     = timeout_q;

  assign bus_data_out       = (init1_grant & init1_data)  | (init2_grant & init2_data);
  assign bus_data_out_valid = (init1_grant & init1_valid) | (init2_grant & init2_valid);
  assign bus_mode_out       = (init1_grant & init1_mode)  | (init2_grant & init2_mode);
  assign bus_rw_out         = (init1_grant & init1_rw)    | (init2_grant & init2_rw);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// request/valid traffic, all compared against a transaction-level model.
module tb_bus_arbiter;

  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init1_req, init2_req, init1_data, init2_data;
  logic       init1_valid, init2_valid, init1_mode, init2_mode;
  logic       init1_rw, init2_rw;
  logic       init1_grant, init2_grant;
  logic       bus_data_out, bus_data_out_valid, bus_mode_out, bus_rw_out;
  logic [1:0] owner;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Model: who holds the bus (0/1/2), who held it last, how many consecutive
  // owner-quiet cycles have elapsed, and whether a watchdog pulse is due.
  int m_owner, m_last, m_quiet;
  bit m_timeout;

  bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .init1_req(init1_req), .init2_req(init2_req),
    .init1_data(init1_data), .init2_data(init2_data),
    .init1_valid(init1_valid), .init2_valid(init2_valid),
    .init1_mode(init1_mode), .init2_mode(init2_mode),
    .init1_rw(init1_rw), .init2_rw(init2_rw),
    .init1_grant(init1_grant), .init2_grant(init2_grant),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
    .bus_mode_out(bus_mode_out), .bus_rw_out(bus_rw_out),
    .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_quiet = 0; m_timeout = 1'b0;
  endtask

  task automatic model_step();
    bit oreq, oval;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner == 0) begin
      m_timeout = 1'b0;
      if (init1_req && (!init2_req || m_last == 2)) m_owner = 1;
      else if (init2_req) m_owner = 2;
      if (m_owner != 0) begin
        m_last  = m_owner;
        m_quiet = 0;
      end
    end else begin
      oreq = (m_owner == 1) ? init1_req : init2_req;
      oval = (m_owner == 1) ? init1_valid : init2_valid;
      m_timeout = 1'b0;
      if (!oreq) begin
        m_owner = 0;
      end else if (oval) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT) begin
          m_owner   = 0;
          m_timeout = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_bus;
    exp_bus = (m_owner == 1) ? {init1_data, init1_valid, init1_mode, init1_rw} :
              (m_owner == 2) ? {init2_data, init2_valid, init2_mode, init2_rw} : 4'b0000;
    check("grant1", init1_grant, m_owner == 1);
    check("grant2", init2_grant, m_owner == 2);
    check("owner", owner, m_owner);
    check("timeout", timeout, m_timeout);
    check("bus", {bus_data_out, bus_data_out_valid, bus_mode_out, bus_rw_out}, exp_bus);
  endtask

  // Inputs change mid-cycle; outputs are checked 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    check_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grants"}, {init1_grant, init2_grant}, 2'b00);
    check({tag, "_owner"}, owner, 2'b00);
    check({tag, "_bus"}, {bus_data_out, bus_data_out_valid, bus_mode_out, bus_rw_out}, 4'b0000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive1(input logic d, input logic v, input logic m, input logic w);
    init1_data = d; init1_valid = v; init1_mode = m; init1_rw = w;
    #1;
    check("i1_bit", {bus_data_out, bus_data_out_valid, bus_mode_out, bus_rw_out}, {d, v, m, w});
    tick();
  endtask

  initial begin
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          p_valid;
    rst_n = 1'b0;
    {init1_req, init2_req, init1_data, init2_data} = '0;
    {init1_valid, init2_valid, init1_mode, init2_mode, init1_rw, init2_rw} = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    check("reset_timeout", timeout, 1'b0);
    rst_n = 1'b1;

    // Single requester: address 0x4000 then 8 data bits, bit-exact on the bus.
    init1_req = 1'b1;
    tick();
    check("first_grant", {init1_grant, owner}, {1'b1, 2'b01});
    addr  = 16'h4000;
    wdata = 8'hA5;
    for (int i = 15; i >= 0; i--) drive1(addr[i], 1'b1, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--)  drive1(wdata[i], 1'b1, 1'b1, 1'b1);
    init1_valid = 1'b0; init1_req = 1'b0;
    tick();
    check("release", owner, 2'b00);

    // Tie after reset goes to init1; handover to init2 takes two edges.
    do_reset();
    init1_req = 1'b1; init2_req = 1'b1;
    tick();
    check("tie_winner", owner, 2'b01);
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    init1_req = 1'b0; init1_valid = 1'b0;
    tick();
    check_all_zero("turnaround");
    tick();
    check("handover", {init2_grant, owner}, {1'b1, 2'b10});

    // init1 lines toggle while init2 owns the bus.
    for (int i = 0; i < 12; i++) begin
      {init1_data, init1_valid, init1_mode, init1_rw} = 4'($urandom);
      {init2_data, init2_valid, init2_mode, init2_rw} = 4'($urandom);
      #1;
      check("isolate", {bus_data_out, bus_data_out_valid, bus_mode_out, bus_rw_out},
            {init2_data, init2_valid, init2_mode, init2_rw});
      tick();
    end
    init2_req = 1'b0;
    {init1_data, init1_valid, init1_mode, init1_rw} = '0;
    {init2_data, init2_valid, init2_mode, init2_rw} = '0;
    tick();

    // Watchdog: init1 granted, never valid, keeps requesting.
    do_reset();
    init1_req = 1'b1;
    tick();
    check("wd_grant", owner, 2'b01);
    init2_req = 1'b1;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      check("wd_hold", {init1_grant, timeout}, 2'b10);
    end
    tick();
    check("wd_fire", {init1_grant, owner, timeout}, {1'b0, 2'b00, 1'b1});
    tick();
    check("wd_regrant", {init2_grant, owner, timeout}, {1'b1, 2'b10, 1'b0});
    init2_req = 1'b0;
    init1_req = 1'b0;
    tick();

    // Reset in the middle of a data phase, then a fresh grant.
    init1_req = 1'b1;
    tick();
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive1(1'b0, 1'b1, 1'b1, 1'b1);
    do_reset();
    init1_valid = 1'b0;
    tick();
    check("post_reset_grant", {init1_grant, owner}, {1'b1, 2'b01});
    init1_req = 1'b0;
    tick();

    // Random traffic; quiet stretches exercise the watchdog.
    p_valid = 50;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) p_valid = ($urandom_range(0, 1) == 0) ? 3 : 60;
      if (!init1_req) init1_req = ($urandom_range(0, 3) == 0);
      else            init1_req = ($urandom_range(0, 15) != 0);
      if (!init2_req) init2_req = ($urandom_range(0, 3) == 0);
      else            init2_req = ($urandom_range(0, 15) != 0);
      init1_valid = ($urandom_range(0, 99) < p_valid);
      init2_valid = ($urandom_range(0, 99) < p_valid);
      {init1_data, init1_mode, init1_rw, init2_data, init2_mode, init2_rw} = 6'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-initiator arbiter for the bit-serial bus. Grants one initiator at a time and muxes that initiator's bit stream onto the shared bus lines (`bus_data_in`, `bus_data_in_valid`, `bus_mode`, `bus_rw`) seen by the address decoder and targets. Ownership is round-robin, held for the whole transaction, with a watchdog that reclaims a stalled bus.

## Interface
- `TIMEOUT_CYCLES`, default 64: number of consecutive owner-idle cycles (`initN_valid`=0) in BUSY that force a release; legal range ≥2.
- `clk` in 1: bus clock.
- `rst_n` in 1: asynchronous, active-low reset; one clock domain only.
- `init1_req`, `init2_req` in 1: bus request; level, held for the whole transaction.
- `init1_data`, `init2_data` in 1: serial bit from the initiator.
- `init1_valid`, `init2_valid` in 1: bit valid.
- `init1_mode`, `init2_mode` in 1: 1 = data phase, 0 = address phase.
- `init1_rw`, `init2_rw` in 1: 1 = write, 0 = read.
- `init1_grant`, `init2_grant` out 1: registered grant; at most one high.
- `bus_data_out` out 1: muxed serial bit, connects to the decoder's `bus_data_in`.
- `bus_data_out_valid` out 1: muxed valid.
- `bus_mode_out` out 1: muxed mode.
- `bus_rw_out` out 1: muxed rw.
- `owner` out 2: 00 none, 01 init1, 10 init2; 11 never driven.
- `timeout` out 1: one-cycle pulse on a watchdog release.

## Operation
- States: IDLE and BUSY. Registers: state, owner, last_owner, idle counter.
- IDLE: no grant. All bus outputs are 0, which presents the "address phase, not valid" condition and clears the decoder's address shifter.
  - Only one request high: that initiator wins.
  - Both requests high: the initiator that is not last_owner wins. After reset, last_owner = init2, so init1 wins the first tie.
  - On a win: owner, last_owner and grant load; go to BUSY.
- BUSY: bus outputs equal the owner's four inputs combinationally, gated by the registered grant. The non-owner's inputs are ignored completely.
- Release when the owner's req is sampled low: grant and owner clear, go to IDLE.
- Watchdog:
  - The idle counter increments each BUSY cycle with owner valid = 0 and clears on owner valid = 1.
  - When it reaches TIMEOUT_CYCLES-1 while owner valid is still 0: forced release to IDLE and `timeout` pulses.
  - The timed-out initiator keeps its req high. It is re-arbitrated like any other requester, with last_owner = itself.
- The counter is ⌈log2(TIMEOUT_CYCLES)⌉ bits, saturates (never wraps), and clears on entry to BUSY.
- The arbiter never cuts a transaction on its own except through the watchdog. Bit and phase framing is the initiator's responsibility.

## Timing
- Reset values: state IDLE, both grants 0, owner 00, `timeout` 0, all bus outputs 0, counter 0, last_owner init2.
- Grant latency: req sampled high in IDLE at edge n → grant high after edge n. The owner drives its first bit in the cycle after it sees the grant.
- Bus mux: zero latency from owner inputs to bus outputs while grant is high.
- Release: req sampled low at edge n → grant low and bus outputs 0 after edge n.
- Turnaround: at least one IDLE cycle between owners, including re-grant of the same initiator. Handover from req-low to the other grant takes 2 edges.
- Simultaneous release and competing request: the release completes first, and the competitor is arbitrated in the following IDLE cycle.
- Reset mid-transaction: grants, owner and bus outputs go to 0 immediately (async). A partial transaction is dropped, and the decoder sees valid = 0.

## Structure
- Shared `serial_bus_pkg` holds:
  - `arb_state_t` enum {ARB_IDLE, ARB_BUSY};
  - owner encoding constants OWNER_NONE, OWNER_I1, OWNER_I2 (2-bit);
  - default timeout constant.
- Single module, no sub-module: the arbitration, counter and mux are small enough to stay inline.

## Test plan
- Reset, then init1_req=1 → init1_grant=1 one edge later, owner=01. A 16-bit address 0x4000 plus 8 data bits appear bit-exact on the bus outputs.
- Both req raised in the same cycle after reset → init1 granted. init1 drops req → one IDLE cycle with bus outputs 0, then init2_grant=1, owner=10.
- init2 owns the bus while init1 toggles its data, valid, mode and rw lines → bus outputs track init2 only.
- TIMEOUT_CYCLES=8, init1 granted with valid held 0 and req held 1 → after 8 BUSY cycles, `timeout` pulses once, grant drops, owner=00. With init2 requesting, init2 is granted next.
- rst_n asserted mid-data-phase → grants, owner and bus outputs are 0 asynchronously. After release, a fresh request is granted normally.
